// File: rtl/i2c_register_bank.sv
// I2C register bank: OSD RAM write window, paged; config/status bytes; snapshot counters; command pulses.
// Reads return data 2 cycles after addr. Writes take effect on the writeEn cycle. There is no backpressure: every writeEn cycle is one write.
module i2c_register_bank #(
   parameter int                   NUM_CFG      = 8,
   parameter logic [7:0]           CFG_BASE     = 8'h81,
   parameter logic [8*NUM_CFG-1:0] CFG_RESET    = {8{8'h00}},
   parameter int                   NUM_STATUS   = 9,
   parameter logic [7:0]           STATUS_BASE  = 8'hB0,
   parameter int                   NUM_COUNTERS = 6,
   parameter int                   RAM_ADDR_W   = 10,
   parameter int                   PULSE_CYCLES = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [7:0]                  addr,
   input  logic [7:0]                  dataIn,
   input  logic                        writeEn,
   output logic [7:0]                  dataOut,
   output logic [7:0]                  ram_dataIn,
   output logic [RAM_ADDR_W-1:0]       ram_wraddress,
   output logic                        ram_wren,
   output logic [8*NUM_CFG-1:0]        cfg_out,
   input  logic [8*NUM_STATUS-1:0]     status_in,
   input  logic [32*NUM_COUNTERS-1:0]  counters_in,
   output logic [NUM_COUNTERS-1:0]     clear_counters,
   output logic [7:0]                  cmd_pulse
);

   localparam int P      = RAM_ADDR_W - 7;
   localparam int CW     = $clog2(PULSE_CYCLES + 1);
   localparam int CFG_LO = int'(CFG_BASE);
   localparam int CFG_HI = CFG_LO + NUM_CFG - 1;
   localparam int ST_LO  = int'(STATUS_BASE);
   localparam int ST_HI  = ST_LO + NUM_STATUS - 1;
   localparam int CT_LO  = 192;
   localparam int CT_HI  = CT_LO + 4 * NUM_COUNTERS - 1;

   function automatic bit f_ovl(input int alo, input int ahi, input int blo, input int bhi);
      return !((ahi < blo) || (bhi < alo));
   endfunction

   // Fixed regions: 0x00-0x80 (OSD + page) and 0xF0 upward, including anything past 0xFF.
   localparam bit MAP_BAD =
      f_ovl(CFG_LO, CFG_HI, 0, 128) || f_ovl(CFG_LO, CFG_HI, 240, 511) ||
      f_ovl(ST_LO, ST_HI, 0, 128)   || f_ovl(ST_LO, ST_HI, 240, 511)   ||
      f_ovl(CT_LO, CT_HI, 0, 128)   || f_ovl(CT_LO, CT_HI, 240, 511)   ||
      f_ovl(CFG_LO, CFG_HI, ST_LO, ST_HI) || f_ovl(CFG_LO, CFG_HI, CT_LO, CT_HI) ||
      f_ovl(ST_LO, ST_HI, CT_LO, CT_HI) ||
      (NUM_CFG < 1) || (NUM_CFG > 15) || (NUM_STATUS < 1) || (NUM_STATUS > 16) ||
      (NUM_COUNTERS < 1) || (NUM_COUNTERS > 8) || (RAM_ADDR_W < 8) || (RAM_ADDR_W > 15) ||
      (PULSE_CYCLES < 1);

   generate
      if (MAP_BAD) begin : g_bad_map
         $error("i2c_register_bank: illegal parameters or overlapping address regions");
      end
   endgenerate

   logic [7:0]              r_addr_q;
   logic [7:0]              r_data_out;
   logic [P-1:0]            r_page;
   logic [8*NUM_CFG-1:0]    r_cfg;
   logic [31:0]             r_shadow [NUM_COUNTERS];
   logic [CW-1:0]           r_cnt [8];
   logic [7:0]              r_pulse;
   logic [NUM_COUNTERS-1:0] r_clear;
   logic                    r_ram_wren;
   logic [RAM_ADDR_W-1:0]   r_ram_wraddress;
   logic [7:0]              r_ram_dataIn;
   logic [7:0]              w_rd_dat;
   logic                    w_osd_wr;

   assign w_osd_wr = writeEn && !addr[7];

   // Second read stage: decode the address registered one cycle earlier.
   always_comb begin
      w_rd_dat = '0;
      if (r_addr_q == 8'h80) w_rd_dat = 8'(r_page);
      for (int i = 0; i < NUM_CFG; i++)
         if (r_addr_q == 8'(CFG_LO + i)) w_rd_dat = r_cfg[8*i +: 8];
      for (int i = 0; i < NUM_STATUS; i++)
         if (r_addr_q == 8'(ST_LO + i)) w_rd_dat = status_in[8*i +: 8];
      for (int k = 0; k < NUM_COUNTERS; k++)
         for (int b = 0; b < 4; b++)
            if (r_addr_q == 8'(CT_LO + 4*k + b)) w_rd_dat = r_shadow[k][8*(3-b) +: 8];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr_q        <= '0;
         r_data_out      <= '0;
         r_page          <= '0;
         r_cfg           <= CFG_RESET;
         r_pulse         <= '0;
         r_clear         <= '0;
         r_ram_wren      <= 1'b0;
         r_ram_wraddress <= '0;
         r_ram_dataIn    <= '0;
         for (int k = 0; k < NUM_COUNTERS; k++) r_shadow[k] <= '0;
         for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
      end else begin
         r_addr_q   <= addr;
         r_data_out <= w_rd_dat;
         r_ram_wren <= w_osd_wr;
         if (w_osd_wr) begin
            r_ram_wraddress <= {r_page, addr[6:0]};
            r_ram_dataIn    <= dataIn;
         end
         if (writeEn && addr == 8'h80) r_page <= dataIn[P-1:0];
         for (int i = 0; i < NUM_CFG; i++)
            if (writeEn && addr == 8'(CFG_LO + i)) r_cfg[8*i +: 8] <= dataIn;
         // Snapshot only when arriving at the MSB byte, so an MSB-to-LSB read sees one value.
         for (int k = 0; k < NUM_COUNTERS; k++)
            if (addr == 8'(CT_LO + 4*k) && r_addr_q != addr) r_shadow[k] <= counters_in[32*k +: 32];
         r_clear <= (writeEn && addr == 8'hF8) ? dataIn[NUM_COUNTERS-1:0] : '0;
         for (int i = 0; i < 8; i++) begin
            if (writeEn && addr == 8'(240 + i)) begin
               r_cnt[i]   <= CW'(PULSE_CYCLES);
               r_pulse[i] <= 1'b1;
            end else if (r_cnt[i] != '0) begin
               r_cnt[i]   <= r_cnt[i] - CW'(1);
               r_pulse[i] <= (r_cnt[i] != CW'(1));
            end else begin
               r_pulse[i] <= 1'b0;
            end
         end
      end
   end

   assign dataOut        = r_data_out;
   assign ram_dataIn     = r_ram_dataIn;
   assign ram_wraddress  = r_ram_wraddress;
   assign ram_wren       = r_ram_wren;
   assign cfg_out        = r_cfg;
   assign clear_counters = r_clear;
   assign cmd_pulse      = r_pulse;

endmodule

// File: tb/tb_i2c_register_bank.sv
// Bench for i2c_register_bank: directed plan sequences, a write/read vector table, then random traffic against a reference model.
module tb_i2c_register_bank;
   localparam int NC = 8, NS = 9, NK = 6, AW = 10, PC = 16;
   localparam logic [63:0] CFG_RST = 64'h8877_6655_4433_2211;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [7:0]     addr = '0, dataIn = '0;
   logic           writeEn = 1'b0;
   logic [7:0]     dataOut, ram_dataIn, cmd_pulse;
   logic [AW-1:0]  ram_wraddress;
   logic           ram_wren;
   logic [8*NC-1:0] cfg_out;
   logic [8*NS-1:0] status_in = '0;
   logic [32*NK-1:0] counters_in = '0;
   logic [NK-1:0]  clear_counters;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   i2c_register_bank #(
      .NUM_CFG(NC), .CFG_BASE(8'h81), .CFG_RESET(CFG_RST), .NUM_STATUS(NS),
      .STATUS_BASE(8'hB0), .NUM_COUNTERS(NK), .RAM_ADDR_W(AW), .PULSE_CYCLES(PC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .addr(addr), .dataIn(dataIn), .writeEn(writeEn),
      .dataOut(dataOut), .ram_dataIn(ram_dataIn), .ram_wraddress(ram_wraddress),
      .ram_wren(ram_wren), .cfg_out(cfg_out), .status_in(status_in),
      .counters_in(counters_in), .clear_counters(clear_counters), .cmd_pulse(cmd_pulse)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic we);
      @(negedge clk);
      addr = a; dataIn = d; writeEn = we;
      @(posedge clk);
      #1;
   endtask

   // Reference model state
   int          m_page;
   logic [7:0]  m_cfg [NC];
   logic [31:0] m_shadow [NK];
   int          m_pend [8];

   function automatic logic [7:0] model_read(input logic [7:0] a);
      int ai;
      ai = int'(a);
      if (ai == 128) return 8'(m_page);
      if (ai >= 129 && ai < 129 + NC) return m_cfg[ai - 129];
      if (ai >= 176 && ai < 176 + NS) return status_in[8*(ai - 176) +: 8];
      if (ai >= 192 && ai < 192 + 4*NK) return 8'(m_shadow[(ai - 192) / 4] >> (8 * (3 - (ai - 192) % 4)));
      return 8'h00;
   endfunction

   typedef struct { logic [7:0] wa; logic [7:0] wd; logic [7:0] ra; logic [7:0] exp; } vec_t;
   vec_t vt [11];

   initial begin
      int hi;
      logic [63:0] rst_bytes;
      logic [7:0] a, d, prev_a, exp_rd;
      logic we, exp_wren;
      logic [AW-1:0] exp_wa;
      logic [7:0] exp_wd, exp_pulse;
      logic [NK-1:0] exp_clr;
      logic [8*NC-1:0] exp_cfg;

      vt[0]  = '{8'h80, 8'hFF, 8'h80, 8'h07};
      vt[1]  = '{8'h81, 8'h3C, 8'h81, 8'h3C};
      vt[2]  = '{8'h88, 8'hC3, 8'h88, 8'hC3};
      vt[3]  = '{8'h89, 8'h77, 8'h89, 8'h00};
      vt[4]  = '{8'hB0, 8'h55, 8'hB0, 8'hA0};
      vt[5]  = '{8'hB8, 8'h55, 8'hB8, 8'hA8};
      vt[6]  = '{8'hB9, 8'h55, 8'hB9, 8'h00};
      vt[7]  = '{8'h82, 8'h99, 8'h81, 8'h3C};
      vt[8]  = '{8'hF8, 8'h00, 8'hF8, 8'h00};
      vt[9]  = '{8'hFF, 8'h12, 8'hFF, 8'h00};
      vt[10] = '{8'h80, 8'h02, 8'h80, 8'h02};
      for (int i = 0; i < NS; i++) status_in[8*i +: 8] = 8'(8'hA0 + i);

      // Reset state
      #12;
      chk("rst_dataOut", 64'(dataOut), 64'h0);
      chk("rst_ram_wren", 64'(ram_wren), 64'h0);
      chk("rst_ram_wraddress", 64'(ram_wraddress), 64'h0);
      chk("rst_ram_dataIn", 64'(ram_dataIn), 64'h0);
      chk("rst_cfg_out", 64'(cfg_out), CFG_RST);
      chk("rst_clear", 64'(clear_counters), 64'h0);
      chk("rst_cmd_pulse", 64'(cmd_pulse), 64'h0);
      @(negedge clk) reset_n = 1'b1;

      // Plan 1: reset value read and unmapped read, 2-cycle latency
      cyc(8'h81, 8'h00, 1'b0);
      cyc(8'hE0, 8'h00, 1'b0);
      chk("p1_cfg0_reset", 64'(dataOut), 64'h11);
      cyc(8'h00, 8'h00, 1'b0);
      chk("p1_unmapped", 64'(dataOut), 64'h00);

      // Plan 2: paged OSD write
      cyc(8'h80, 8'h03, 1'b1);
      cyc(8'h05, 8'h5A, 1'b1);
      chk("p2_wren", 64'(ram_wren), 64'h1);
      chk("p2_wraddr", 64'(ram_wraddress), 64'h185);
      chk("p2_wdata", 64'(ram_dataIn), 64'h5A);
      cyc(8'h05, 8'h00, 1'b0);
      chk("p2_wren_drop", 64'(ram_wren), 64'h0);

      // Plan 3: atomic counter snapshot
      counters_in[32 +: 32] = 32'h1234_5678;
      cyc(8'hC4, 8'h00, 1'b0);
      counters_in[32 +: 32] = 32'hFFFF_FFFF;
      cyc(8'hC5, 8'h00, 1'b0);
      chk("p3_byte0", 64'(dataOut), 64'h12);
      cyc(8'hC6, 8'h00, 1'b0);
      chk("p3_byte1", 64'(dataOut), 64'h34);
      cyc(8'hC7, 8'h00, 1'b0);
      chk("p3_byte2", 64'(dataOut), 64'h56);
      cyc(8'h00, 8'h00, 1'b0);
      chk("p3_byte3", 64'(dataOut), 64'h78);

      // Plan 4: pulse length and retrigger
      hi = 0;
      cyc(8'hF2, 8'h00, 1'b1);
      hi += int'(cmd_pulse[2]);
      for (int i = 0; i < 30; i++) begin
         cyc(8'h00, 8'h00, 1'b0);
         hi += int'(cmd_pulse[2]);
      end
      chk("p4_pulse_len", 64'(hi), 64'd16);
      hi = 0;
      cyc(8'hF2, 8'h00, 1'b1);
      hi += int'(cmd_pulse[2]);
      for (int i = 0; i < 9; i++) begin
         cyc(8'h00, 8'h00, 1'b0);
         hi += int'(cmd_pulse[2]);
      end
      cyc(8'hF2, 8'h00, 1'b1);
      hi += int'(cmd_pulse[2]);
      for (int i = 0; i < 30; i++) begin
         cyc(8'h00, 8'h00, 1'b0);
         hi += int'(cmd_pulse[2]);
      end
      chk("p4_retrigger_len", 64'(hi), 64'd26);

      // Plan 5: clear mask, single and back-to-back
      cyc(8'hF8, 8'h05, 1'b1);
      chk("p5_clear", 64'(clear_counters), 64'h05);
      cyc(8'h00, 8'h00, 1'b0);
      chk("p5_clear_drop", 64'(clear_counters), 64'h00);
      cyc(8'hF8, 8'hC1, 1'b1);
      chk("p5_clear_b2b0", 64'(clear_counters), 64'h01);
      cyc(8'hF8, 8'h02, 1'b1);
      chk("p5_clear_b2b1", 64'(clear_counters), 64'h02);

      // Write/read vector table
      for (int i = 0; i < 11; i++) begin
         cyc(vt[i].wa, vt[i].wd, 1'b1);
         cyc(vt[i].ra, 8'h00, 1'b0);
         cyc(8'h00, 8'h00, 1'b0);
         chk($sformatf("table%0d", i), 64'(dataOut), 64'(vt[i].exp));
      end

      // Plan 6: asynchronous reset during pulse and OSD write
      cyc(8'hF3, 8'h00, 1'b1);
      cyc(8'h10, 8'hAA, 1'b1);
      chk("p6_pre_wren", 64'(ram_wren), 64'h1);
      chk("p6_pre_pulse", 64'(cmd_pulse), 64'h08);
      #2 reset_n = 1'b0;
      writeEn = 1'b0;
      #1;
      chk("p6_wren", 64'(ram_wren), 64'h0);
      chk("p6_pulse", 64'(cmd_pulse), 64'h0);
      chk("p6_cfg", 64'(cfg_out), CFG_RST);
      chk("p6_wraddr", 64'(ram_wraddress), 64'h0);
      @(negedge clk);
      addr = 8'h00; dataIn = 8'h00;
      reset_n = 1'b1;

      // Random traffic against the model
      m_page = 0;
      rst_bytes = CFG_RST;
      for (int i = 0; i < NC; i++) m_cfg[i] = rst_bytes[8*i +: 8];
      for (int k = 0; k < NK; k++) m_shadow[k] = '0;
      for (int i = 0; i < 8; i++) m_pend[i] = 0;
      prev_a = 8'h00;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         case ($urandom_range(0, 9))
            0: a = 8'($urandom_range(0, 127));
            1: a = 8'h80;
            2: a = 8'(129 + $urandom_range(0, NC - 1));
            3: a = 8'(176 + $urandom_range(0, NS - 1));
            4, 5, 6: a = 8'(192 + $urandom_range(0, 4*NK - 1));
            7: a = 8'(240 + $urandom_range(0, 7));
            8: a = 8'hF8;
            default: a = 8'($urandom_range(0, 255));
         endcase
         d = 8'($urandom);
         we = ($urandom_range(0, 2) != 0);
         addr = a; dataIn = d; writeEn = we;
         for (int i = 0; i < NS; i++) status_in[8*i +: 8] = 8'($urandom);
         for (int k = 0; k < NK; k++) counters_in[32*k +: 32] = $urandom;

         exp_rd = model_read(prev_a);
         if (int'(a) >= 192 && int'(a) < 192 + 4*NK && (int'(a) - 192) % 4 == 0 && a != prev_a)
            m_shadow[(int'(a) - 192) / 4] = counters_in[32*((int'(a) - 192) / 4) +: 32];
         exp_wren = we && (int'(a) < 128);
         exp_wa = AW'(m_page * 128 + int'(a) % 128);
         exp_wd = d;
         exp_clr = (we && a == 8'hF8) ? d[NK-1:0] : '0;
         if (we && a == 8'h80) m_page = int'(d) % 8;
         if (we && int'(a) >= 129 && int'(a) < 129 + NC) m_cfg[int'(a) - 129] = d;
         if (we && int'(a) >= 240 && int'(a) < 248) m_pend[int'(a) - 240] = n + PC;
         for (int i = 0; i < NC; i++) exp_cfg[8*i +: 8] = m_cfg[i];
         for (int i = 0; i < 8; i++) exp_pulse[i] = (n < m_pend[i]);
         prev_a = a;

         @(posedge clk);
         #1;
         chk("rnd_dataOut", 64'(dataOut), 64'(exp_rd));
         chk("rnd_ram_wren", 64'(ram_wren), 64'(exp_wren));
         if (exp_wren) begin
            chk("rnd_wraddr", 64'(ram_wraddress), 64'(exp_wa));
            chk("rnd_wdata", 64'(ram_dataIn), 64'(exp_wd));
         end
         chk("rnd_clear", 64'(clear_counters), 64'(exp_clr));
         chk("rnd_pulse", 64'(cmd_pulse), 64'(exp_pulse));
         chk("rnd_cfg", 64'(cfg_out), 64'(exp_cfg));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i2c_register_bank.md
Name: i2c_register_bank

Overview:
Parametrised I2C register bank. It succeeds the fixed-map OSD/config register interface and sits between the i2c slave byte engine and the video/OSD/reset logic. It provides:
- a paged OSD RAM write window;
- N generic read/write config bytes;
- M read-only status bytes;
- K 32-bit event counters with atomic 4-byte snapshot reads;
- 8 stretched command pulses;
- a counter-clear mask command.

Parameters:
NUM_CFG, 8, number of config bytes at CFG_BASE (1..15)
CFG_BASE, 8'h81, address of config byte 0
CFG_RESET, {8{8'h00}}, flattened reset values, byte i at [8i+7:8i]
NUM_STATUS, 9, number of status bytes at STATUS_BASE (1..16)
STATUS_BASE, 8'hB0, address of status byte 0
NUM_COUNTERS, 6, number of 32-bit counters at 8'hC0 (1..8)
RAM_ADDR_W, 10, OSD RAM address width (>=8); page width P = RAM_ADDR_W-7
PULSE_CYCLES, 16, command pulse length in clk cycles (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
addr  in  8  register address from i2c slave
dataIn  in  8  write data
writeEn  in  1  write strobe; each high cycle is one write
dataOut  out  8  read data, 2-cycle latency
ram_dataIn  out  8  OSD RAM write data (= registered dataIn)
ram_wraddress  out  RAM_ADDR_W  OSD RAM write address
ram_wren  out  1  OSD RAM write enable
cfg_out  out  8*NUM_CFG  config bytes, flattened
status_in  in  8*NUM_STATUS  status bytes, flattened
counters_in  in  32*NUM_COUNTERS  live counters, flattened
clear_counters  out  NUM_COUNTERS  one-cycle clear request per counter
cmd_pulse  out  8  stretched command pulses

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - dataOut=0, ram_wren=0, ram_wraddress=0, ram_dataIn=0.
  - page=0, cfg_out=CFG_RESET.
  - shadows=0, clear_counters=0, cmd_pulse=0, all pulse counters=0.
- Address map:
  - 0x00-0x7F: OSD window.
  - 0x80: page (read/write; upper bits read 0).
  - CFG_BASE..CFG_BASE+NUM_CFG-1: config bytes.
  - STATUS_BASE..+NUM_STATUS-1: status bytes, read-only.
  - 0xC0+4k..0xC3+4k: counter k, big-endian, read-only.
  - 0xF0-0xF7: command pulse 0-7, write-only.
  - 0xF8: clear_counters mask, write-only.
  - Any other address reads 0; writes to it are ignored.
  - Overlapping regions are illegal. Elaboration fails via a generate-time check.
- OSD write (writeEn & addr<0x80):
  - Next cycle: ram_wren=1, ram_wraddress={page, addr[6:0]}, ram_dataIn=dataIn.
  - ram_wren drops the cycle after writeEn drops.
- Write to 0x80 in the same cycle as an OSD write is impossible (single addr). A page change affects only later writes.
- Config write: cfg byte updates on the writeEn cycle and is visible on cfg_out the next cycle.
- Read pipeline:
  - Stage 1 registers addr into addr_q and performs the snapshot.
  - Stage 2 muxes dataOut.
  - dataOut reflects addr from 2 cycles earlier. Writes to readable registers are visible 2 cycles after the write cycle.
- Counter snapshot:
  - When addr==0xC0+4k and addr_q!=addr (entering the MSB byte), shadow_k <= counters_in[k] that cycle.
  - All 4 bytes of counter k read from shadow_k, so a sequential MSB-to-LSB read is atomic.
  - Reading bytes 1-3 without first entering the MSB byte returns the last shadow.
  - Holding addr on the MSB byte does not re-snapshot.
- Command pulse:
  - A write to 0xF0+i loads cnt_i=PULSE_CYCLES. cmd_pulse[i] = (cnt_i!=0), registered, asserted the cycle after the write.
  - cnt_i decrements each cycle. The pulse lasts exactly PULSE_CYCLES cycles.
  - Retrigger while active reloads the count (pulse extends). dataIn is ignored.
- Counter clear: a write to 0xF8 sets clear_counters <= dataIn[NUM_COUNTERS-1:0] for one cycle, then 0. Writes on consecutive cycles produce consecutive pulses.
- Reset mid-pulse or mid-read: all outputs return immediately to reset values. No pending snapshot survives.

Test Plan:
1. Reset, then read 0x81 -> dataOut=CFG_RESET byte0 2 cycles after addr; read 0xE0 (unmapped) -> 0x00.
2. Write 0x80=0x03, then write addr 0x05 data 0x5A -> ram_wren=1 for 1 cycle, ram_wraddress=0x185, ram_dataIn=0x5A.
3. counters_in[1]=0x12345678, read addr 0xC4; change counters_in[1] to 0xFFFFFFFF; read 0xC5,0xC6,0xC7 -> 0x12,0x34,0x56,0x78.
4. Write 0xF2 with PULSE_CYCLES=16 -> cmd_pulse[2] high exactly 16 cycles; rewrite at cycle 10 -> high 26 cycles total.
5. Write 0xF8=0x05 -> clear_counters=6'b000101 for one cycle, then 0.
6. Assert reset_n=0 during an active cmd_pulse and ram_wren -> both 0 asynchronously; cfg_out returns to CFG_RESET.
